multicycle_ctrl_hs: RTL and testbench

Parametrised multicycle RV32I control FSM. It is the next-generation controller for the multicycle core and sits between the instruction register and the datapath muxes, register file and memory port. Compared with the previous controller, it adds a memory ready handshake with a wait-state timeout, and LUI/AUIPC support. It also adds branch-outcome gating, an illegal-opcode trap and optional performance counters.

---
 rtl/mc_ctrl_pkg.sv | 61 ++++++
 rtl/multicycle_ctrl_hs_if.sv | 40 ++++
 rtl/mc_mem_timeout.sv | 37 +++
 rtl/multicycle_ctrl_hs.sv | 188 ++++++++++++++++++
 tb/tb_multicycle_ctrl_hs.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared state type, RV32I opcode constants and datapath mux/ALU encodings
// for the multicycle controller.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StUpper,
        StBranch,
        StJump,
        StTrap
    } state_t;

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcARs1   = 2'b01;
    localparam logic [1:0] SrcAOldPc = 2'b10;

    localparam logic [1:0] SrcBRs2   = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;

    localparam logic [1:0] AluAdd    = 2'b00;
    localparam logic [1:0] AluSub    = 2'b01;
    localparam logic [1:0] AluFunct  = 2'b10;
    localparam logic [1:0] AluPassB  = 2'b11;

    localparam logic [1:0] WbAluOut  = 2'b00;
    localparam logic [1:0] WbMdr     = 2'b01;
    localparam logic [1:0] WbPc      = 2'b10;
    localparam logic [1:0] WbImm     = 2'b11;

    localparam logic PcSrcAlu    = 1'b0;
    localparam logic PcSrcAluOut = 1'b1;

    // State that follows DECODE for a given opcode; unknown opcodes trap.
    function automatic state_t decode_next(input logic [6:0] opc);
        state_t nxt;
        unique case (opc)
            OpcOp, OpcOpImm, OpcLoad, OpcStore: nxt = StExec;
            OpcBranch:                          nxt = StBranch;
            OpcJal, OpcJalr:                    nxt = StJump;
            OpcLui, OpcAuipc:                   nxt = StUpper;
            default:                            nxt = StTrap;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_hs_if.sv
// Controller-to-datapath bundle: IR opcode, memory handshake, register enables,
// mux selects, exception pulses and performance counters.
interface multicycle_ctrl_hs_if #(
    parameter int unsigned ALU_OP_W = 2,
    parameter int unsigned CNT_W    = 32
);
    logic [6:0]          opcode;
    logic                branch_taken;
    logic                mem_ready;
    logic                mem_req;
    logic                mem_we;
    logic                pc_write;
    logic                ir_write;
    logic                reg_write;
    logic                aluout_write;
    logic                mdr_write;
    logic [1:0]          alu_src_a;
    logic [1:0]          alu_src_b;
    logic [ALU_OP_W-1:0] alu_op;
    logic [1:0]          wb_sel;
    logic                pc_src;
    logic                illegal;
    logic                mem_fault;
    logic [CNT_W-1:0]    cycle_cnt;
    logic [CNT_W-1:0]    instret_cnt;

    modport master (
        input  opcode, branch_taken, mem_ready,
        output mem_req, mem_we, pc_write, ir_write, reg_write, aluout_write, mdr_write,
        output alu_src_a, alu_src_b, alu_op, wb_sel, pc_src, illegal, mem_fault,
        output cycle_cnt, instret_cnt
    );

    modport slave (
        output opcode, branch_taken, mem_ready,
        input  mem_req, mem_we, pc_write, ir_write, reg_write, aluout_write, mdr_write,
        input  alu_src_a, alu_src_b, alu_op, wb_sel, pc_src, illegal, mem_fault,
        input  cycle_cnt, instret_cnt
    );
endinterface

// File: rtl/mc_mem_timeout.sv
// Memory wait-state counter: counts request cycles without ready and pulses
// mem_fault on the MEM_TIMEOUT-th consecutive one (MEM_TIMEOUT = 0 disables).
module mc_mem_timeout #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mem_req,
    input  logic mem_ready,
    output logic mem_fault
);
    localparam bit          En    = (MEM_TIMEOUT != 0);
    localparam int unsigned Limit = En ? MEM_TIMEOUT - 1 : 0;
    localparam int unsigned CntW  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            waiting;

    assign waiting   = mem_req & ~mem_ready;
    // A ready in the limit cycle wins, since waiting is then low.
    assign mem_fault = En & waiting & (cnt_q == CntW'(Limit));

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (!waiting || mem_fault) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/multicycle_ctrl_hs.sv
// Multicycle RV32I control FSM with memory ready handshake and wait timeout.
// Optional performance counters are built when MC_PERF_CNT_EN is defined.
module multicycle_ctrl_hs
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned ALU_OP_W    = 2,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_ctrl_hs_if.master bus
);
    state_t     state_q;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       branch_taken;

    logic       mem_req_c, mem_we_c, pc_write_c, ir_write_c, reg_write_c;
    logic       aluout_write_c, mdr_write_c, pc_src_c, illegal_c;
    logic [1:0] src_a_c, src_b_c, alu_op_c, wb_sel_c;
    logic       mem_req_g;
    logic       mem_fault;

    assign opcode       = bus.opcode;
    assign mem_ready    = bus.mem_ready;
    assign branch_taken = bus.branch_taken;

    always_comb begin
        mem_req_c      = 1'b0;
        mem_we_c       = 1'b0;
        pc_write_c     = 1'b0;
        ir_write_c     = 1'b0;
        reg_write_c    = 1'b0;
        aluout_write_c = 1'b0;
        mdr_write_c    = 1'b0;
        pc_src_c       = PcSrcAlu;
        illegal_c      = 1'b0;
        src_a_c        = SrcAPc;
        src_b_c        = SrcBRs2;
        alu_op_c       = AluAdd;
        wb_sel_c       = WbAluOut;
        unique case (state_q)
            StFetch: begin
                mem_req_c  = 1'b1;
                src_a_c    = SrcAPc;
                src_b_c    = SrcBFour;
                alu_op_c   = AluAdd;
                pc_src_c   = PcSrcAlu;
                ir_write_c = mem_ready;
                pc_write_c = mem_ready;
            end
            StDecode: begin
                // Branch/JAL target precomputed into ALUOut.
                src_a_c        = SrcAOldPc;
                src_b_c        = SrcBImm;
                alu_op_c       = AluAdd;
                aluout_write_c = 1'b1;
            end
            StExec: begin
                src_a_c        = SrcARs1;
                src_b_c        = (opcode == OpcOp) ? SrcBRs2 : SrcBImm;
                alu_op_c       = (opcode == OpcOp || opcode == OpcOpImm) ? AluFunct : AluAdd;
                aluout_write_c = 1'b1;
            end
            StMem: begin
                mem_req_c   = 1'b1;
                mem_we_c    = (opcode == OpcStore);
                mdr_write_c = mem_ready && (opcode == OpcLoad);
            end
            StWb: begin
                reg_write_c = 1'b1;
                wb_sel_c    = (opcode == OpcLoad) ? WbMdr : WbAluOut;
            end
            StUpper: begin
                aluout_write_c = 1'b1;
                src_b_c        = SrcBImm;
                if (opcode == OpcLui) begin
                    alu_op_c = AluPassB;
                end else begin
                    src_a_c  = SrcAOldPc;
                    alu_op_c = AluAdd;
                end
            end
            StBranch: begin
                src_a_c    = SrcARs1;
                src_b_c    = SrcBRs2;
                alu_op_c   = AluSub;
                pc_src_c   = PcSrcAluOut;
                pc_write_c = branch_taken;
            end
            StJump: begin
                // PC not yet updated, so wb_sel=PC writes the link address PC+4.
                reg_write_c = 1'b1;
                wb_sel_c    = WbPc;
                pc_write_c  = 1'b1;
                if (opcode == OpcJalr) begin
                    src_a_c  = SrcARs1;
                    src_b_c  = SrcBImm;
                    alu_op_c = AluAdd;
                    pc_src_c = PcSrcAlu;
                end else begin
                    pc_src_c = PcSrcAluOut;
                end
            end
            StTrap: begin
                illegal_c = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem_req_g = rst_n & mem_req_c;

    mc_mem_timeout #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_req   (mem_req_g),
        .mem_ready (mem_ready),
        .mem_fault (mem_fault)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StFetch;
        end else begin
            unique case (state_q)
                StFetch:  if (mem_ready) state_q <= StDecode;
                StDecode: state_q <= decode_next(opcode);
                StExec:   state_q <= (opcode == OpcLoad || opcode == OpcStore) ? StMem : StWb;
                StMem: begin
                    if (mem_ready) begin
                        state_q <= (opcode == OpcLoad) ? StWb : StFetch;
                    end else if (mem_fault) begin
                        state_q <= StFetch;
                    end
                end
                StUpper:  state_q <= StWb;
                default:  state_q <= StFetch;
            endcase
        end
    end

    assign bus.mem_req      = mem_req_g;
    assign bus.mem_we       = rst_n & mem_we_c;
    assign bus.pc_write     = rst_n & pc_write_c;
    assign bus.ir_write     = rst_n & ir_write_c;
    assign bus.reg_write    = rst_n & reg_write_c;
    assign bus.aluout_write = rst_n & aluout_write_c;
    assign bus.mdr_write    = rst_n & mdr_write_c;
    assign bus.pc_src       = rst_n & pc_src_c;
    assign bus.illegal      = rst_n & illegal_c;
    assign bus.mem_fault    = mem_fault;
    assign bus.alu_src_a    = rst_n ? src_a_c : 2'b00;
    assign bus.alu_src_b    = rst_n ? src_b_c : 2'b00;
    assign bus.alu_op       = rst_n ? ALU_OP_W'(alu_op_c) : {ALU_OP_W{1'b0}};
    assign bus.wb_sel       = rst_n ? wb_sel_c : 2'b00;

`ifdef MC_PERF_CNT_EN
    logic             retire;
    logic [CNT_W-1:0] cycle_q, instret_q;

    // A store retires on its ready cycle; trap and timeout exits never do.
    assign retire = (state_q == StWb) || (state_q == StBranch) || (state_q == StJump) ||
                    (state_q == StMem && opcode == OpcStore && mem_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q <= cycle_q + CNT_W'(1);
            if (retire) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    assign bus.cycle_cnt   = rst_n ? cycle_q : {CNT_W{1'b0}};
    assign bus.instret_cnt = rst_n ? instret_q : {CNT_W{1'b0}};
`else
    assign bus.cycle_cnt   = {CNT_W{1'b0}};
    assign bus.instret_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_multicycle_ctrl_hs.sv
// Randomised bench for multicycle_ctrl_hs against an instruction-path model,
// with directed opening sequences pinned by literal expectations.
module tb_multicycle_ctrl_hs;
    localparam int unsigned Tmo  = 4;
    localparam int unsigned CntW = 8;
`ifdef MC_PERF_CNT_EN
    localparam bit Perf = 1'b1;
`else
    localparam bit Perf = 1'b0;
`endif

    localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011, BR = 7'b1100011, JAL = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;
    localparam logic [6:0] SYS = 7'b1110011;

    // Bit positions inside the packed 18-bit control snapshot.
    localparam int BMreq = 17, BMwe = 16, BPcw = 15, BIrw = 14, BRw = 13, BAow = 12;
    localparam int BMdw = 11, BPcs = 2, BIll = 1, BFlt = 0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_ctrl_hs_if #(.ALU_OP_W(2), .CNT_W(CntW)) bus ();

    multicycle_ctrl_hs #(
        .ALU_OP_W    (2),
        .CNT_W       (CntW),
        .MEM_TIMEOUT (Tmo)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: position within the current instruction's phase path.
    int            m_idx  = 0;
    int            m_wait = 0;
    logic [CntW-1:0] m_cyc = '0;
    logic [CntW-1:0] m_ins = '0;

    logic [17:0]     s_ctl;
    logic [CntW-1:0] s_cyc, s_ins;

    function automatic string path_of(input logic [6:0] op);
        case (op)
            OP, OPI:     return "FDEW";
            LD:          return "FDEMW";
            ST:          return "FDEM";
            BR:          return "FDB";
            JAL, JALR:   return "FDJ";
            LUI, AUIPC:  return "FDUW";
            default:     return "FDT";
        endcase
    endfunction

    function automatic logic [17:0] exp_ctl(input logic [7:0] ph, input logic [6:0] op,
                                            input logic rdy, input logic tk, input int w,
                                            input logic r);
        logic mreq, mwe, pcw, irw, rw, aow, mdw, pcs, ill, flt;
        logic [1:0] sa, sb, ao, wb;
        {mreq, mwe, pcw, irw, rw, aow, mdw, pcs, ill, flt} = '0;
        {sa, sb, ao, wb} = '0;
        if (ph == "F") begin
            mreq = 1; sb = 2'b01; irw = rdy; pcw = rdy;
        end else if (ph == "D") begin
            sa = 2'b10; sb = 2'b10; aow = 1;
        end else if (ph == "E") begin
            sa = 2'b01; sb = (op == OP) ? 2'b00 : 2'b10;
            ao = (op == OP || op == OPI) ? 2'b10 : 2'b00; aow = 1;
        end else if (ph == "M") begin
            mreq = 1; mwe = (op == ST); mdw = rdy && (op == LD);
        end else if (ph == "W") begin
            rw = 1; wb = (op == LD) ? 2'b01 : 2'b00;
        end else if (ph == "U") begin
            aow = 1; sb = 2'b10;
            if (op == LUI) ao = 2'b11;
            else sa = 2'b10;
        end else if (ph == "B") begin
            sa = 2'b01; ao = 2'b01; pcs = 1; pcw = tk;
        end else if (ph == "J") begin
            rw = 1; wb = 2'b10; pcw = 1;
            if (op == JALR) begin sa = 2'b01; sb = 2'b10; end
            else pcs = 1;
        end else if (ph == "T") begin
            ill = 1;
        end
        flt = mreq && !rdy && (Tmo != 0) && (w == int'(Tmo) - 1);
        if (!r) return '0;
        return {mreq, mwe, pcw, irw, rw, aow, mdw, sa, sb, ao, wb, pcs, ill, flt};
    endfunction

    function automatic logic [17:0] dut_ctl();
        return {bus.mem_req, bus.mem_we, bus.pc_write, bus.ir_write, bus.reg_write,
                bus.aluout_write, bus.mdr_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                bus.wb_sel, bus.pc_src, bus.illegal, bus.mem_fault};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // One clock cycle: drive, compare against the model, then advance the model.
    task automatic tick(input logic r, input logic [6:0] op, input logic rdy, input logic tk);
        string      p;
        logic [7:0] ph;
        logic [17:0] e;
        bit         adv;
        rst_n = r; bus.opcode = op; bus.mem_ready = rdy; bus.branch_taken = tk;
        #2;
        p  = path_of(op);
        ph = p[m_idx];
        e  = exp_ctl(ph, op, rdy, tk, m_wait, r);
        s_ctl = dut_ctl();
        s_cyc = bus.cycle_cnt;
        s_ins = bus.instret_cnt;
        check($sformatf("ctl phase %c op %b", ph, op), 32'(s_ctl), 32'(e));
        check("cycle_cnt", 32'(s_cyc), 32'((r && Perf) ? m_cyc : '0));
        check("instret_cnt", 32'(s_ins), 32'((r && Perf) ? m_ins : '0));
        @(posedge clk);
        adv = 1'b0;
        if (!r) begin
            m_idx = 0; m_wait = 0; m_cyc = '0; m_ins = '0;
        end else begin
            m_cyc = m_cyc + 1'b1;
            if (ph == "F" || ph == "M") begin
                if (rdy) begin
                    m_wait = 0; adv = 1'b1;
                end else if (Tmo != 0 && m_wait == int'(Tmo) - 1) begin
                    m_wait = 0; m_idx = 0;
                end else begin
                    m_wait++;
                end
            end else begin
                m_wait = 0; adv = 1'b1;
            end
            if (adv) begin
                m_idx++;
                if (m_idx == p.len()) begin
                    m_idx = 0;
                    if (ph != "T") m_ins = m_ins + 1'b1;
                end
            end
        end
        #1;
    endtask

    function automatic logic [6:0] rand_op();
        case ($urandom_range(0, 10))
            0: return OP;    1: return OPI;  2: return LD;   3: return ST;
            4: return BR;    5: return JAL;  6: return JALR; 7: return LUI;
            8: return AUIPC; 9: return SYS;
            default: return 7'($urandom);
        endcase
    endfunction

    initial begin
        logic [6:0] op_cur;
        logic       r;
        int         rdy_pct;
        rst_n = 1'b0; bus.opcode = '0; bus.mem_ready = 1'b1; bus.branch_taken = 1'b0;
        #1;
        repeat (3) tick(1'b0, 7'h00, 1'b1, 1'b0);
        check("reset outputs", 32'(s_ctl), 32'd0);

        // ADDI
        tick(1'b1, OPI, 1'b1, 1'b0);
        check("first fetch req/ir/pc", 32'({s_ctl[BMreq], s_ctl[BIrw], s_ctl[BPcw]}), 32'b111);
        tick(1'b1, OPI, 1'b1, 1'b0);
        tick(1'b1, OPI, 1'b1, 1'b0);
        tick(1'b1, OPI, 1'b1, 1'b0);
        check("addi wb reg_write/wb_sel", 32'({s_ctl[BRw], s_ctl[4:3]}), 32'b100);

        // LW with three wait cycles in MEM
        tick(1'b1, LD, 1'b1, 1'b0);
        check("instret after addi", 32'(s_ins), Perf ? 32'd1 : 32'd0);
        tick(1'b1, LD, 1'b1, 1'b0);
        tick(1'b1, LD, 1'b1, 1'b0);
        repeat (3) begin
            tick(1'b1, LD, 1'b0, 1'b0);
            check("lw wait req/mdr", 32'({s_ctl[BMreq], s_ctl[BMdw]}), 32'b10);
        end
        tick(1'b1, LD, 1'b1, 1'b0);
        check("lw ready req/mdr", 32'({s_ctl[BMreq], s_ctl[BMdw]}), 32'b11);
        tick(1'b1, LD, 1'b1, 1'b0);
        check("lw wb reg_write/wb_sel", 32'({s_ctl[BRw], s_ctl[4:3]}), 32'b101);

        // BEQ not taken, then taken
        tick(1'b1, BR, 1'b1, 1'b0);
        tick(1'b1, BR, 1'b1, 1'b0);
        tick(1'b1, BR, 1'b1, 1'b0);
        check("beq not taken pc_write", 32'(s_ctl[BPcw]), 32'd0);
        tick(1'b1, BR, 1'b1, 1'b1);
        tick(1'b1, BR, 1'b1, 1'b1);
        tick(1'b1, BR, 1'b1, 1'b1);
        check("beq taken pc_write/pc_src", 32'({s_ctl[BPcw], s_ctl[BPcs]}), 32'b11);

        // Illegal opcode
        tick(1'b1, 7'h00, 1'b1, 1'b0);
        check("instret after beq x2", 32'(s_ins), Perf ? 32'd4 : 32'd0);
        tick(1'b1, 7'h00, 1'b1, 1'b0);
        tick(1'b1, 7'h00, 1'b1, 1'b0);
        check("trap illegal", 32'(s_ctl[BIll]), 32'd1);

        // Fetch timeout, then ready arriving exactly in the limit cycle
        repeat (3) tick(1'b1, 7'h00, 1'b0, 1'b0);
        check("trap pulse single cycle", 32'(s_ctl[BIll]), 32'd0);
        tick(1'b1, 7'h00, 1'b0, 1'b0);
        check("fault on 4th wait", 32'(s_ctl[BFlt]), 32'd1);
        tick(1'b1, 7'h00, 1'b0, 1'b0);
        check("refetch req/ir/fault", 32'({s_ctl[BMreq], s_ctl[BIrw], s_ctl[BFlt]}), 32'b100);
        check("instret after trap/fault", 32'(s_ins), Perf ? 32'd4 : 32'd0);
        repeat (2) tick(1'b1, 7'h00, 1'b0, 1'b0);
        tick(1'b1, OPI, 1'b1, 1'b0);
        check("ready in limit cycle fault/ir", 32'({s_ctl[BFlt], s_ctl[BIrw]}), 32'b01);
        tick(1'b1, OPI, 1'b1, 1'b0);
        check("decode after late ready", 32'({s_ctl[BAow], s_ctl[10:9]}), 32'b110);
        tick(1'b1, OPI, 1'b1, 1'b0);
        tick(1'b1, OPI, 1'b1, 1'b0);

        // Random traffic; opcode only changes while fetching
        op_cur  = OPI;
        rdy_pct = 75;
        for (int i = 0; i < 4000; i++) begin
            if (i % 50 == 0) rdy_pct = ($urandom_range(0, 1) != 0) ? 75 : 30;
            r = ($urandom_range(0, 499) != 0);
            if (m_idx == 0) op_cur = rand_op();
            tick(r, op_cur, ($urandom_range(0, 99) < rdy_pct), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1, "watchdog");
    end
endmodule
